// File: rtl/pwm_controller_if.sv
// Configuration write port of pwm_controller.
//
// Handshake: cfg_valid is a single-cycle write strobe with no ready/back-pressure.
// The slave always accepts, sampling cfg_addr/cfg_data on the rising clk edge
// where cfg_valid is high. The master must hold cfg_addr/cfg_data stable for
// that cycle only.
//
// Signals:
//   cfg_valid  1  write strobe
//   cfg_addr   7  register address (0x00-0x04 decoded, others ignored)
//   cfg_data   8  write data
interface pwm_controller_if;
  logic       cfg_valid;
  logic [6:0] cfg_addr;
  logic [7:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data);
  modport slave  (input  cfg_valid, input  cfg_addr, input  cfg_data);
endinterface

// File: rtl/pwm_controller.sv
// Double-buffered PWM controller for 16 outputs.
//
// Register writes land in shadow registers. The shadow set is copied to the
// active set atomically at the PWM period boundary (wrap event), so an output
// never shows a half-updated configuration.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   cfg             configuration write port (slave side)
//   out[15:0]       registered output pins
//   period_start    one-clk pulse on the first clk of each PWM period
//   update_pending  shadow written but not yet committed to active
//
// Register map (shadow and active):
//   0x00 en[7:0]   0x01 en[15:8]
//   0x02 mode[7:0] 0x03 mode[15:8]   (1 = PWM, 0 = static high)
//   0x04 duty[7:0]
module pwm_controller #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_controller_if.slave cfg,
  output logic [15:0]     out,
  output logic            period_start,
  output logic            update_pending
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        wrap;
  logic        write_hit;

  logic [15:0] shadow_en;
  logic [15:0] shadow_mode;
  logic [7:0]  shadow_duty;
  logic [15:0] active_en;
  logic [15:0] active_mode;
  logic [7:0]  active_duty;

  logic        pwm_level;
  logic [15:0] out_next;

  assign tick      = (pre_cnt == PRE_LAST);
  assign wrap      = tick && (pwm_cnt == 8'hFF);
  assign write_hit = cfg.cfg_valid && (cfg.cfg_addr <= 7'd4);

  // Prescaler: one tick every PRESCALE clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // Period counter: 256 ticks per period, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Shadow registers take writes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_en   <= '0;
      shadow_mode <= '0;
      shadow_duty <= '0;
    end else if (write_hit) begin
      case (cfg.cfg_addr[2:0])
        3'd0:    shadow_en[7:0]    <= cfg.cfg_data;
        3'd1:    shadow_en[15:8]   <= cfg.cfg_data;
        3'd2:    shadow_mode[7:0]  <= cfg.cfg_data;
        3'd3:    shadow_mode[15:8] <= cfg.cfg_data;
        3'd4:    shadow_duty       <= cfg.cfg_data;
        default: ;
      endcase
    end
  end

  // Active registers copy the shadow on the wrap edge. A write on the same
  // edge only reaches the shadow, so active sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_en   <= '0;
      active_mode <= '0;
      active_duty <= '0;
    end else if (wrap) begin
      active_en   <= shadow_en;
      active_mode <= shadow_mode;
      active_duty <= shadow_duty;
    end
  end

  // A write wins over the commit clear: the new data is still uncommitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_pending <= 1'b0;
    end else if (write_hit) begin
      update_pending <= 1'b1;
    end else if (wrap) begin
      update_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  // 0xFF needs its own case: pwm_cnt < 0xFF is false for the last tick.
  always_comb begin
    pwm_level = 1'b0;
    if (active_duty == 8'hFF) begin
      pwm_level = 1'b1;
    end else if (active_duty != 8'h00) begin
      pwm_level = (pwm_cnt < active_duty);
    end
  end

  // Disabled -> 0, static -> 1, PWM -> shared level.
  always_comb begin
    out_next = active_en & (~active_mode | {16{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_controller.sv
module tb_pwm_controller;

  localparam int PRESCALE = 13;
  localparam int P = 256 * PRESCALE;

  logic        clk;
  logic        rst_n;
  logic [15:0] out;
  logic        period_start;
  logic        update_pending;

  pwm_controller_if cfg_bus ();

  pwm_controller #(.PRESCALE(PRESCALE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg            (cfg_bus),
    .out            (out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == k after the k-th rising edge following reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  // per-window observation statistics
  int       s_hi0;
  int       s_fall0;
  logic     prev0;
  int       s_other_nz;
  int       s_nz;
  int       s_lo_nz;
  int       s_ub_bad;
  logic [7:0] s_ub_exp;
  int       s_ps;
  int       s_ps_last;
  int       s_ps_gap;

  task automatic clear_stats(input logic [7:0] ub_exp);
    s_hi0 = 0; s_fall0 = 0; prev0 = out[0];
    s_other_nz = 0; s_nz = 0; s_lo_nz = 0; s_ub_bad = 0;
    s_ub_exp = ub_exp; s_ps = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (out[0]) s_hi0++;
    if (prev0 && !out[0] && s_fall0 == 0) s_fall0 = cyc;
    prev0 = out[0];
    if (out[15:1] != 15'd0) s_other_nz++;
    if (out != 16'd0) s_nz++;
    if (out[7:0] != 8'd0) s_lo_nz++;
    if (out[15:8] !== s_ub_exp) s_ub_bad++;
    if (period_start) begin
      s_ps++;
      if (s_ps_last >= 0) s_ps_gap = cyc - s_ps_last;
      s_ps_last = cyc;
    end
  endtask

  task automatic run_to(input int t);
    for (int n = 0; n < 100000 && cyc < t; n++) step();
    total++;
    if (cyc != t) begin
      bad++;
      $display("FAIL run_to_timeout got=%0d want=%0d", cyc, t);
    end
  endtask

  // drive on a falling edge, captured by the next rising edge
  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_data  = d;
    step();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s_ps_last = -1;
    s_ps_gap = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%0h want=0", out); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%0b want=0", period_start); end
    total++; if (update_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b want=0", update_pending); end
    rst_n = 1'b1;
    s_ps_last = -1;
    s_ps_gap = 0;
    clear_stats(8'h00);
  endtask

  task automatic test_commit_static();
    run_to(4);
    write_reg(7'h00, 8'hFF);
    write_reg(7'h01, 8'h0F);
    exp_q.push_back(32'h0000_0FFF);
    total++; if (update_pending !== 1'b1) begin bad++; $display("FAIL commit_pending_set got=%0b want=1", update_pending); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL commit_early_out got=%0h want=0", out); end
    clear_stats(8'h00);
    run_to(P - 1);
    total++; if (s_nz != 0) begin bad++; $display("FAIL commit_out_before_wrap got=%0d want=0", s_nz); end
    total++; if (s_ps != 0) begin bad++; $display("FAIL first_period_ps got=%0d want=0", s_ps); end
    total++; if (update_pending !== 1'b1) begin bad++; $display("FAIL commit_pending_hold got=%0b want=1", update_pending); end
    step();
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL commit_ps got=%0b want=1", period_start); end
    total++; if (update_pending !== 1'b0) begin bad++; $display("FAIL commit_pending_clr got=%0b want=0", update_pending); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL commit_out_wrapclk got=%0h want=0", out); end
    step();
    exp = exp_q.pop_front();
    total++; if ({16'h0, out} !== exp) begin bad++; $display("FAIL commit_out got=%0h want=%0h", out, exp); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL ps_width got=%0b want=0", period_start); end
  endtask

  task automatic test_pwm_half();
    write_reg(7'h00, 8'h01);
    write_reg(7'h01, 8'h00);
    write_reg(7'h02, 8'h01);
    write_reg(7'h04, 8'h80);
    exp_q.push_back(32'(128 * PRESCALE));
    exp_q.push_back(32'(2 * P + 128 * PRESCALE + 1));
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'(P));
    run_to(2 * P);
    clear_stats(8'h00);
    run_to(3 * P);
    exp = exp_q.pop_front();
    total++; if (32'(s_hi0) !== exp) begin bad++; $display("FAIL pwm80_high_clks got=%0d want=%0d", s_hi0, exp); end
    exp = exp_q.pop_front();
    total++; if (32'(s_fall0) !== exp) begin bad++; $display("FAIL pwm80_fall_cyc got=%0d want=%0d", s_fall0, exp); end
    exp = exp_q.pop_front();
    total++; if (32'(s_other_nz) !== exp) begin bad++; $display("FAIL pwm80_other_bits got=%0d want=%0d", s_other_nz, exp); end
    exp = exp_q.pop_front();
    total++; if (32'(s_ps) !== exp) begin bad++; $display("FAIL pwm80_ps_count got=%0d want=%0d", s_ps, exp); end
    exp = exp_q.pop_front();
    total++; if (32'(s_ps_gap) !== exp) begin bad++; $display("FAIL ps_spacing got=%0d want=%0d", s_ps_gap, exp); end
  endtask

  task automatic test_duty_extremes();
    write_reg(7'h00, 8'h00);
    write_reg(7'h01, 8'hFF);
    write_reg(7'h02, 8'h00);
    write_reg(7'h03, 8'hFF);
    write_reg(7'h04, 8'h00);
    run_to(4 * P);
    clear_stats(8'h00);
    run_to(6 * P);
    total++; if (s_ub_bad != 0) begin bad++; $display("FAIL duty00_upper got=%0d want=0", s_ub_bad); end
    total++; if (s_lo_nz != 0) begin bad++; $display("FAIL duty00_lower got=%0d want=0", s_lo_nz); end
    total++; if (s_ps != 2) begin bad++; $display("FAIL duty00_ps_count got=%0d want=2", s_ps); end
    write_reg(7'h04, 8'hFF);
    run_to(7 * P);
    clear_stats(8'hFF);
    run_to(9 * P);
    total++; if (s_ub_bad != 0) begin bad++; $display("FAIL dutyFF_upper got=%0d want=0", s_ub_bad); end
    total++; if (s_lo_nz != 0) begin bad++; $display("FAIL dutyFF_lower got=%0d want=0", s_lo_nz); end
  endtask

  task automatic test_back_to_back();
    write_reg(7'h00, 8'h01);
    write_reg(7'h01, 8'h00);
    write_reg(7'h02, 8'h01);
    write_reg(7'h03, 8'h00);
    write_reg(7'h04, 8'h40);
    write_reg(7'h04, 8'hC0);
    exp_q.push_back(32'(8'hC0 * PRESCALE));
    run_to(10 * P);
    clear_stats(8'h00);
    run_to(11 * P);
    exp = exp_q.pop_front();
    total++; if (32'(s_hi0) !== exp) begin bad++; $display("FAIL last_write_wins got=%0d want=%0d", s_hi0, exp); end
    total++; if (s_other_nz != 0) begin bad++; $display("FAIL b2b_other_bits got=%0d want=0", s_other_nz); end
  endtask

  task automatic test_wrap_collision();
    write_reg(7'h04, 8'h10);
    exp_q.push_back(32'(8'h10 * PRESCALE));
    exp_q.push_back(32'(8'h20 * PRESCALE));
    run_to(12 * P - 1);
    write_reg(7'h04, 8'h20);
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL collide_on_wrap got=%0b want=1", period_start); end
    total++; if (update_pending !== 1'b1) begin bad++; $display("FAIL collide_pending got=%0b want=1", update_pending); end
    clear_stats(8'h00);
    run_to(13 * P - 1);
    total++; if (update_pending !== 1'b1) begin bad++; $display("FAIL collide_pending_hold got=%0b want=1", update_pending); end
    step();
    total++; if (update_pending !== 1'b0) begin bad++; $display("FAIL collide_pending_clr got=%0b want=0", update_pending); end
    exp = exp_q.pop_front();
    total++; if (32'(s_hi0) !== exp) begin bad++; $display("FAIL collide_old_duty got=%0d want=%0d", s_hi0, exp); end
    clear_stats(8'h00);
    run_to(14 * P);
    exp = exp_q.pop_front();
    total++; if (32'(s_hi0) !== exp) begin bad++; $display("FAIL collide_new_duty got=%0d want=%0d", s_hi0, exp); end
  endtask

  task automatic test_ignored_and_reset();
    write_reg(7'h05, 8'hAA);
    write_reg(7'h7F, 8'h55);
    total++; if (update_pending !== 1'b0) begin bad++; $display("FAIL bad_addr_pending got=%0b want=0", update_pending); end
    exp_q.push_back(32'(8'h20 * PRESCALE));
    run_to(15 * P);
    clear_stats(8'h00);
    run_to(16 * P);
    exp = exp_q.pop_front();
    total++; if (32'(s_hi0) !== exp) begin bad++; $display("FAIL bad_addr_no_change got=%0d want=%0d", s_hi0, exp); end
    total++; if (s_other_nz != 0) begin bad++; $display("FAIL bad_addr_other_bits got=%0d want=0", s_other_nz); end
    write_reg(7'h04, 8'hFF);
    write_reg(7'h01, 8'hFF);
    run_to(16 * P + 100);
    total++; if (out !== 16'h0001) begin bad++; $display("FAIL pre_reset_out got=%0h want=1", out); end
    total++; if (update_pending !== 1'b1) begin bad++; $display("FAIL pre_reset_pending got=%0b want=1", update_pending); end
    rst_n = 1'b0;
    #1;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL async_reset_out got=%0h want=0", out); end
    total++; if (update_pending !== 1'b0) begin bad++; $display("FAIL async_reset_pending got=%0b want=0", update_pending); end
    do_reset();
    clear_stats(8'h00);
    run_to(P - 1);
    total++; if (s_nz != 0) begin bad++; $display("FAIL post_reset_out got=%0d want=0", s_nz); end
    total++; if (s_ps != 0) begin bad++; $display("FAIL post_reset_ps got=%0d want=0", s_ps); end
    step();
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL post_reset_first_ps got=%0b want=1", period_start); end
    step();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL shadow_discarded got=%0h want=0", out); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    s_ps_last = -1;
    s_ps_gap = 0;
    s_ub_exp = 8'h00;
    test_reset();
    test_commit_static();
    test_pwm_half();
    test_duty_extremes();
    test_back_to_back();
    test_wrap_collision();
    test_ignored_and_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_controller.md
Name: pwm_controller

Overview:
- Double-buffered configuration and PWM sequencing block for the 16 chip outputs.
- Accepts register writes from the SPI register-write port (addresses 0x00-0x04) into shadow registers.
- Commits the shadow registers atomically at the PWM period boundary.
- Drives each output as off, static high, or PWM at the shared duty cycle.

Parameters:
- PRESCALE, 13, clk cycles per PWM tick (legal range 1-65535); PWM period = 256 ticks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- cfg_valid  input  1  single-cycle write strobe from SPI register-write port
- cfg_addr  input  7  register address
- cfg_data  input  8  write data
- out  output  16  registered output pins: out[7:0] to uo_out, out[15:8] to uio_out
- period_start  output  1  one-cycle pulse on the first clk of each PWM period
- update_pending  output  1  high while shadow differs from active (written, not yet committed)

Behaviour:
- Register map (shadow, then active):
  - 0x00 en[7:0]
  - 0x01 en[15:8]
  - 0x02 mode[7:0] (1 = PWM, 0 = static)
  - 0x03 mode[15:8]
  - 0x04 duty[7:0]
- Write handling:
  - cfg_valid with cfg_addr <= 4 writes cfg_data to that shadow register on the same clk edge and sets update_pending.
  - cfg_addr > 4 is ignored: no shadow change, pending unchanged.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick is asserted when pre_cnt == PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Period counter:
  - 8-bit pwm_cnt increments on tick, wrapping 255 -> 0.
  - wrap event = tick && pwm_cnt == 255.
- Commit:
  - On wrap event, all five active registers load from shadow in the same edge and update_pending clears.
  - If cfg_valid coincides with the wrap event: active takes the pre-write shadow value, shadow takes the new data, update_pending stays 1.
- period_start: registered; high for exactly one clk, the cycle after the wrap event (i.e. while pwm_cnt == 0 for its first clk).
- PWM level:
  - duty == 0x00 -> 0.
  - duty == 0xFF -> constant 1.
  - otherwise 1 when pwm_cnt < duty.
- Per-output value, registered (one-clk latency from active/pwm_cnt):
  - en[i]=0 -> 0.
  - en[i]=1, mode[i]=0 -> 1.
  - en[i]=1, mode[i]=1 -> PWM level.
- Latency:
  - A write becomes visible on out no earlier than the clk after the next wrap event.
  - Worst case is 256*PRESCALE + 1 clks.
- Reset:
  - All outputs and registers clear: shadow, active, pre_cnt, pwm_cnt, out=16'h0000, period_start=0, update_pending=0.
  - Reset mid-period discards pending shadow data. After release, counting restarts at pre_cnt=0, pwm_cnt=0.
  - period_start does not pulse for the post-reset period; the first pulse follows the first wrap.
- No combinational path from cfg_* to any output.

Test Plan:
1. Reset, then write 0x00=0xFF and 0x01=0x0F with mode=0 -> out stays 0x0000 and update_pending=1 until the first wrap; out=0x0FFF on the clk after the wrap, pending=0.
2. en[0]=1, mode[0]=1, duty=0x80, PRESCALE=13 -> out[0] high for exactly 128*13 clks, low for 128*13 clks per period; period_start spacing = 3328 clks.
3. duty=0x00 and duty=0xFF with PWM mode on out[15:8] -> out[15:8] constant 0x00 and constant 0xFF respectively across two full periods.
4. Write 0x04=0x40, then 0x04=0xC0 in the same period -> only 0xC0 is committed; out never shows a 0x40 duty period.
5. cfg_valid on the exact wrap-event clk (0x04=0x20, shadow previously 0x10) -> next period uses duty 0x10, update_pending remains 1, the following period uses 0x20.
6. Write 0x05 and 0x7F with any data -> no shadow change, update_pending stays 0. Assert rst_n low mid-period with pending writes -> out=0x0000 immediately (asynchronous), pending cleared, post-reset outputs stay 0.
